// File: rtl/match_pe_lane_pkg.sv
// Shared constants, types and the match-length encoder for the match PE lane.
package match_pe_lane_pkg;

  localparam int unsigned ADDR_WIDTH         = 32;
  localparam int unsigned MATCH_PE_WIDTH     = 32;
  localparam int unsigned PE_WIDTH_LOG2      = 5;
  localparam int unsigned MAX_MATCH_LEN_LOG2 = 5;
  localparam int unsigned LEN_WIDTH          = MAX_MATCH_LEN_LOG2 + 1;

  typedef logic [MATCH_PE_WIDTH*8-1:0] chunk_t;
  typedef logic [MATCH_PE_WIDTH-1:0]   match_vec_t;

  // Count of consecutive ones starting at bit 0 (0..MATCH_PE_WIDTH).
  function automatic logic [LEN_WIDTH-1:0] match_len_encode(input match_vec_t bits);
    logic [LEN_WIDTH-1:0] len;
    logic                 run;
    len = '0;
    run = 1'b1;
    for (int k = 0; k < MATCH_PE_WIDTH; k++) begin
      run = run & bits[k];
      len = len + LEN_WIDTH'(run);
    end
    return len;
  endfunction

endpackage

// File: rtl/match_pe_lane_window_buffer.sv
// Circular byte window: aligned chunk writes, unaligned chunk reads with a
// registered read pipeline of NBPIPE+1 stages and a read_unsafe flag.
//   write_addr/write_data/write_enable : chunk-aligned, monotonically increasing writes
//   read_addr                           : any byte address
//   read_data/read_unsafe               : registered, NBPIPE+1 cycles after read_addr
module match_pe_lane_window_buffer
  import match_pe_lane_pkg::*;
#(
  parameter int unsigned SIZE_BYTES_LOG2 = 15,
  parameter int unsigned NBPIPE          = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  chunk_t                write_data,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output chunk_t                read_data,
  output logic                  read_unsafe
);

  localparam int unsigned BANK_W = PE_WIDTH_LOG2;
  localparam int unsigned ROW_W  = SIZE_BYTES_LOG2 - BANK_W;
  localparam int unsigned ROWS   = 1 << ROW_W;
  localparam int unsigned SIZE   = 1 << SIZE_BYTES_LOG2;
  localparam int unsigned EXT_W  = ADDR_WIDTH + 1;

  // One bank per byte lane: an aligned write touches every bank at one row,
  // an unaligned read touches every bank at one of two adjacent rows.
  logic [7:0]       mem [MATCH_PE_WIDTH][ROWS];
  logic [EXT_W-1:0] wr_end;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] rd_row;
  logic [BANK_W-1:0] rd_off;
  logic [EXT_W-1:0] rd_end_c;
  chunk_t           rd_data_c;
  logic             rd_unsafe_c;
  chunk_t           data_q [NBPIPE+1];
  logic [NBPIPE:0]  unsafe_q;

  assign wr_row = write_addr[SIZE_BYTES_LOG2-1:BANK_W];
  assign rd_row = read_addr[SIZE_BYTES_LOG2-1:BANK_W];
  assign rd_off = read_addr[BANK_W-1:0];

  // Byte k of the read lives in bank (off+k); it moves to the next row once that wraps.
  for (genvar k = 0; k < MATCH_PE_WIDTH; k++) begin : g_rd
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    assign bank = rd_off + BANK_W'(k);
    assign row  = rd_row + ROW_W'(bank < rd_off);
    assign rd_data_c[8*k +: 8] = mem[bank][row];
  end

  // Unsafe: read runs past the written end, or starts in bytes already overwritten.
  assign rd_end_c    = EXT_W'(read_addr) + EXT_W'(MATCH_PE_WIDTH);
  assign rd_unsafe_c = (rd_end_c > wr_end) ||
                       ((wr_end >= EXT_W'(SIZE)) && (EXT_W'(read_addr) < wr_end - EXT_W'(SIZE)));

  // Window storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      for (int b = 0; b < MATCH_PE_WIDTH; b++) begin
        mem[b][wr_row] <= write_data[8*b +: 8];
      end
    end
  end

  // End of written data, used by the unsafe check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_end <= '0;
    end else if (write_enable) begin
      wr_end <= EXT_W'(write_addr) + EXT_W'(MATCH_PE_WIDTH);
    end
  end

  // Read pipeline.
  always_ff @(posedge clk) begin
    data_q[0]   <= rd_data_c;
    unsafe_q[0] <= rd_unsafe_c;
    for (int unsigned s = 1; s <= NBPIPE; s++) begin
      data_q[s]   <= data_q[s-1];
      unsafe_q[s] <= unsafe_q[s-1];
    end
  end

  assign read_data   = data_q[NBPIPE];
  assign read_unsafe = unsafe_q[NBPIPE];

endmodule

// File: rtl/match_pe_lane.sv
// One match PE lane: compares MATCH_PE_WIDTH bytes of history against the head
// window and returns the leading match length, tagged with idx/last.
//   i_valid/i_idx/i_last/i_head_addr/i_history_addr : request, one per cycle
//   o_valid/o_idx/o_last/o_match_len                : result, NBPIPE+3 cycles later
//   i_write_*                                       : stream write port for both windows
module match_pe_lane
  import match_pe_lane_pkg::*;
#(
  parameter int unsigned SCOREBOARD_ENTRY_INDEX = 2,
  parameter int unsigned NBPIPE                 = 3,
  parameter int unsigned SIZE_LOG2              = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  input  logic [SCOREBOARD_ENTRY_INDEX-1:0] i_idx,
  input  logic                              i_last,
  input  logic [ADDR_WIDTH-1:0]             i_head_addr,
  input  logic [ADDR_WIDTH-1:0]             i_history_addr,
  output logic                              o_valid,
  output logic                              o_last,
  output logic [SCOREBOARD_ENTRY_INDEX-1:0] o_idx,
  output logic [LEN_WIDTH-1:0]              o_match_len,
  input  logic [ADDR_WIDTH-1:0]             i_write_addr,
  input  chunk_t                            i_write_data,
  input  logic                              i_write_enable,
  input  logic                              i_write_history_enable
);

  localparam int unsigned LAT = NBPIPE + 3;

  chunk_t     hist_data;
  chunk_t     head_data;
  logic       hist_unsafe;
  logic       head_unsafe;
  match_vec_t match_c;
  match_vec_t match_q;
  logic [LAT-1:0]                    valid_q;
  logic [LAT-1:0]                    last_q;
  logic [SCOREBOARD_ENTRY_INDEX-1:0] idx_q [LAT];

  match_pe_lane_window_buffer #(
    .SIZE_BYTES_LOG2 (SIZE_LOG2),
    .NBPIPE          (NBPIPE)
  ) u_history (
    .clk          (clk),
    .rst          (rst),
    .write_addr   (i_write_addr),
    .write_data   (i_write_data),
    .write_enable (i_write_enable & i_write_history_enable),
    .read_addr    (i_history_addr),
    .read_data    (hist_data),
    .read_unsafe  (hist_unsafe)
  );

  match_pe_lane_window_buffer #(
    .SIZE_BYTES_LOG2 (MAX_MATCH_LEN_LOG2 + 1),
    .NBPIPE          (NBPIPE)
  ) u_head (
    .clk          (clk),
    .rst          (rst),
    .write_addr   (i_write_addr),
    .write_data   (i_write_data),
    .write_enable (i_write_enable),
    .read_addr    (i_head_addr),
    .read_data    (head_data),
    .read_unsafe  (head_unsafe)
  );

  // Per-byte equality, forced to mismatch if either read is unsafe.
  always_comb begin
    match_c = '0;
    for (int k = 0; k < MATCH_PE_WIDTH; k++) begin
      match_c[k] = (hist_data[8*k +: 8] == head_data[8*k +: 8]) && !(hist_unsafe || head_unsafe);
    end
  end

  // Compare and encoder registers.
  always_ff @(posedge clk) begin
    match_q     <= match_c;
    o_match_len <= match_len_encode(match_q);
  end

  // Valid alignment; in-flight requests are dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[LAT-2:0], i_valid};
    end
  end

  // Tag alignment.
  always_ff @(posedge clk) begin
    last_q   <= {last_q[LAT-2:0], i_last};
    idx_q[0] <= i_idx;
    for (int unsigned s = 1; s < LAT; s++) begin
      idx_q[s] <= idx_q[s-1];
    end
  end

  assign o_valid = valid_q[LAT-1];
  assign o_last  = last_q[LAT-1];
  assign o_idx   = idx_q[LAT-1];

endmodule

// File: tb/tb_match_pe_lane.sv
// Bench for match_pe_lane: directed and randomized requests against a
// byte-addressed reference model of both windows.
module tb_match_pe_lane;
  import match_pe_lane_pkg::*;

  localparam int unsigned IDXW      = 2;
  localparam int unsigned NBPIPE    = 3;
  localparam int unsigned SIZE_LOG2 = 15;
  localparam int          LAT       = NBPIPE + 3;
  localparam longint      W         = 32;
  localparam longint      HIST_SIZE = 32768;
  localparam longint      HEAD_SIZE = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_valid;
  logic [IDXW-1:0]       i_idx;
  logic                  i_last;
  logic [ADDR_WIDTH-1:0] i_head_addr;
  logic [ADDR_WIDTH-1:0] i_history_addr;
  logic                  o_valid;
  logic                  o_last;
  logic [IDXW-1:0]       o_idx;
  logic [LEN_WIDTH-1:0]  o_match_len;
  logic [ADDR_WIDTH-1:0] i_write_addr;
  chunk_t                i_write_data;
  logic                  i_write_enable;
  logic                  i_write_history_enable;

  always #5 clk = ~clk;

  match_pe_lane #(
    .SCOREBOARD_ENTRY_INDEX (IDXW),
    .NBPIPE                 (NBPIPE),
    .SIZE_LOG2              (SIZE_LOG2)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_valid                (i_valid),
    .i_idx                  (i_idx),
    .i_last                 (i_last),
    .i_head_addr            (i_head_addr),
    .i_history_addr         (i_history_addr),
    .o_valid                (o_valid),
    .o_last                 (o_last),
    .o_idx                  (o_idx),
    .o_match_len            (o_match_len),
    .i_write_addr           (i_write_addr),
    .i_write_data           (i_write_data),
    .i_write_enable         (i_write_enable),
    .i_write_history_enable (i_write_history_enable)
  );

  typedef struct {
    bit            valid;
    bit            last;
    bit [IDXW-1:0] idx;
    int            len;
  } exp_t;

  exp_t        pipe_q[$];
  byte unsigned head_m [longint];
  byte unsigned hist_m [longint];
  longint      head_end;
  longint      hist_end;
  int          checks;
  int          errors;

  function automatic bit is_unsafe(longint a, longint wend, longint size);
    return (a + W > wend) || (a < wend - size);
  endfunction

  // Expected result: leading equal bytes, or 0 if either string is unavailable.
  function automatic int model_len(longint h, longint y);
    if (is_unsafe(h, head_end, HEAD_SIZE) || is_unsafe(y, hist_end, HIST_SIZE)) return 0;
    for (int k = 0; k < W; k++) begin
      if (head_m[h + k] != hist_m[y + k]) return k;
    end
    return int'(W);
  endfunction

  // Period-97 byte pattern with occasional random bytes to vary match lengths.
  function automatic chunk_t make_chunk(longint addr, int unsigned flip);
    chunk_t     c;
    logic [7:0] b;
    c = '0;
    for (int k = 0; k < W; k++) begin
      b = 8'((addr + k) % 97);
      if (flip != 0 && $urandom_range(flip - 1, 0) == 0) b = 8'($urandom_range(255, 0));
      c[8*k +: 8] = b;
    end
    return c;
  endfunction

  task automatic push_idle();
    exp_t e;
    e.valid = 1'b0; e.last = 1'b0; e.idx = '0; e.len = 0;
    pipe_q.push_back(e);
  endtask

  task automatic check_out(exp_t e);
    checks++;
    assert (o_valid === e.valid) else begin
      errors++; $error("FAIL valid got %0b want %0b", o_valid, e.valid);
    end
    if (e.valid) begin
      checks++;
      assert (o_idx === e.idx) else begin
        errors++; $error("FAIL idx got %0d want %0d", o_idx, e.idx);
      end
      checks++;
      assert (o_last === e.last) else begin
        errors++; $error("FAIL last got %0b want %0b", o_last, e.last);
      end
      checks++;
      assert (o_match_len === LEN_WIDTH'(e.len)) else begin
        errors++; $error("FAIL match_len got %0d want %0d", o_match_len, e.len);
      end
    end
  endtask

  // One clock: record the expectation, update the model, check the output due now.
  task automatic tick();
    exp_t e;
    e.valid = i_valid;
    e.last  = i_last;
    e.idx   = i_idx;
    e.len   = i_valid ? model_len(longint'(i_head_addr), longint'(i_history_addr)) : 0;
    if (i_write_enable) begin
      for (int k = 0; k < W; k++) head_m[longint'(i_write_addr) + k] = i_write_data[8*k +: 8];
      head_end = longint'(i_write_addr) + W;
      if (i_write_history_enable) begin
        for (int k = 0; k < W; k++) hist_m[longint'(i_write_addr) + k] = i_write_data[8*k +: 8];
        hist_end = longint'(i_write_addr) + W;
      end
    end
    pipe_q.push_back(e);
    @(posedge clk);
    #1;
    if (pipe_q.size() == LAT) check_out(pipe_q.pop_front());
    i_valid = 1'b0;
    i_last = 1'b0;
    i_write_enable = 1'b0;
    i_write_history_enable = 1'b0;
  endtask

  task automatic req(int unsigned idx, bit last, longint h, longint y);
    i_valid = 1'b1;
    i_idx = IDXW'(idx);
    i_last = last;
    i_head_addr = ADDR_WIDTH'(h);
    i_history_addr = ADDR_WIDTH'(y);
  endtask

  task automatic wr(longint addr, chunk_t data, bit hist_en);
    i_write_enable = 1'b1;
    i_write_history_enable = hist_en;
    i_write_addr = ADDR_WIDTH'(addr);
    i_write_data = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0; i_last = 1'b0;
    i_write_enable = 1'b0; i_write_history_enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    assert (o_valid === 1'b0) else begin
      errors++; $error("FAIL reset_valid got %0b want 0", o_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pipe_q.delete();
    repeat (LAT - 1) push_idle();
    head_end = 0;
    hist_end = 0;
  endtask

  initial begin
    chunk_t c0;
    chunk_t c;
    longint nextw;
    longint h;
    longint y;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i_valid = 1'b0; i_idx = '0; i_last = 1'b0;
    i_head_addr = '0; i_history_addr = '0;
    i_write_addr = '0; i_write_data = '0;
    i_write_enable = 1'b0; i_write_history_enable = 1'b0;
    head_end = 0;
    hist_end = 0;
    for (int k = 0; k < W; k++) c0[8*k +: 8] = 8'(k);

    do_reset();

    // Nothing written yet; then a request in the same cycle as the first write.
    req(2, 0, 0, 0); tick();
    wr(0, c0, 1); req(3, 0, 0, 0); tick();
    req(1, 1, 0, 0); tick();
    c = c0; c[8*5 +: 8] = 8'hAA; wr(32, c, 1); tick();
    req(0, 0, 32, 0); tick();
    c = c0; c[7:0] = 8'h55; wr(64, c, 1); tick();
    req(1, 1, 64, 0); tick();
    // Head-only write: history end stays at 96.
    wr(96, c0, 0); tick();
    req(2, 0, 96, 0); tick();
    req(3, 1, 96, 96); tick();
    req(0, 0, 65, 1); tick();
    req(1, 0, 65, 33); tick();
    req(2, 0, 63, 0); tick();
    repeat (LAT) tick();

    // Back-to-back requests, then reset with results in flight.
    for (int i = 0; i < 4; i++) begin
      req(i, i == 3, 64 + i * 8, i * 8); tick();
    end
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++;
    assert (o_valid === 1'b0) else begin
      errors++; $error("FAIL async_reset got %0b want 0", o_valid);
    end
    do_reset();
    repeat (LAT + 4) tick();

    // Fill more than one full history window.
    for (int n = 0; n < (HIST_SIZE + 64) / W; n++) begin
      wr(longint'(n) * W, make_chunk(longint'(n) * W, 16), 1); tick();
    end
    req(0, 0, head_end - W, 0); tick();
    req(1, 0, head_end - W, 63); tick();
    req(2, 1, head_end - W, 64); tick();

    // Random requests, with writes interleaved in the same cycles.
    nextw = hist_end;
    for (int n = 0; n < 300; n++) begin
      h = head_end - W - longint'($urandom_range(32, 0));
      if ($urandom_range(9, 0) == 0) h = head_end - W + longint'($urandom_range(8, 1));
      y = h - 97 * longint'($urandom_range(336, 1));
      case ($urandom_range(3, 0))
        1: y = y + longint'($urandom_range(3, 1));
        2: y = longint'($urandom_range(32'(hist_end + 40), 0));
        default: ;
      endcase
      if (y < 0) y = 0;
      req($urandom_range(3, 0), 1'($urandom_range(1, 0)), h, y);
      if ($urandom_range(2, 0) == 0) begin
        wr(nextw, make_chunk(nextw, 16), 1);
        nextw = nextw + W;
      end
      tick();
    end
    repeat (LAT) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
